// File: rtl/dcm_seq_pkg.sv
// Shared definitions for the DCM reset sequencer: FSM state encoding and
// the widths of the retry counter and the lock/reset timer.
package dcm_seq_pkg;

    localparam int RETRY_W = 4;
    localparam int TIMER_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/freq_drift_cmp.sv
// Combinational drift detector: flags when the measured frequency word differs
// from the latched word by more than the tolerance. Both words are unsigned,
// so the difference is formed in 33 signed bits and can never wrap; a
// difference of exactly the tolerance is not drift.
module freq_drift_cmp (
    input  logic [31:0] i_word,
    input  logic [31:0] i_ref,
    input  logic [31:0] i_tol,
    output logic        o_drift
);

    logic signed [32:0] w_diff;
    logic        [32:0] w_mag;

    // Signed difference, magnitude, then strict compare against the tolerance
    always_comb begin
        w_diff  = $signed({1'b0, i_word}) - $signed({1'b0, i_ref});
        w_mag   = w_diff[32] ? $unsigned(-w_diff) : $unsigned(w_diff);
        o_drift = (w_mag > {1'b0, i_tol});
    end

endmodule

// File: rtl/dcm_reset_sequencer.sv
// DCM reset sequencer. Takes the frequency counter's measurement, applies the
// matching frequency mode to the DCM, pulses DCM reset, waits for lock with a
// timeout and bounded retries, and re-sequences on mode change, drift or lock
// loss. Any loss of a valid in-range measurement aborts to IDLE.
// Optional feature macro: DCM_CLKIN_STOP_EN -- when defined, a synchronised
// I_clkin_stopped forces IDLE from WAIT_LOCK or LOCKED.
// O_dbg_state exposes the FSM state for observation.
module dcm_reset_sequencer
    import dcm_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 8,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned DRIFT_TOL    = 500000
) (
    input  logic               I_clk,
    input  logic               I_reset_n,
    input  logic [31:0]        I_freq_word,
    input  logic               I_freq_mode,
    input  logic               I_freq_or,
    input  logic               I_freq_set,
    input  logic               I_dcm_locked,
    input  logic               I_clkin_stopped,
    output logic               O_dcm_rst,
    output logic               O_dcm_mode,
    output logic               O_ready,
    output logic               O_fault,
    output logic [RETRY_W-1:0] O_retry_cnt,
    output state_t             O_dbg_state
);

    localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [31:0]        TOL       = 32'(DRIFT_TOL);

    state_t               r_state;
    state_t               w_next;
    logic [TIMER_W-1:0]   r_timer;
    logic [RETRY_W-1:0]   r_retry;
    logic [31:0]          r_word;
    logic                 r_mode;
    logic                 r_dcm_rst;
    logic                 r_ready;
    logic                 r_fault;
    logic                 r_lock_ff1;
    logic                 r_lock_ff2;
    logic                 w_locked;
    logic                 w_arm;
    logic                 w_drift;
    logic                 w_clkin_stop;
    logic                 w_latch;
    logic                 w_retry_clr;
    logic                 w_retry_inc;

    assign w_locked = r_lock_ff2;
    assign w_arm    = I_freq_set && !I_freq_or;

    // Two-flop synchroniser for the asynchronous DCM LOCKED status
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_lock_ff1 <= 1'b0;
            r_lock_ff2 <= 1'b0;
        end else begin
            r_lock_ff1 <= I_dcm_locked;
            r_lock_ff2 <= r_lock_ff1;
        end
    end

`ifdef DCM_CLKIN_STOP_EN
    logic r_stop_ff1;
    logic r_stop_ff2;

    // Two-flop synchroniser for the DCM input-clock-stopped status
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_stop_ff1 <= 1'b0;
            r_stop_ff2 <= 1'b0;
        end else begin
            r_stop_ff1 <= I_clkin_stopped;
            r_stop_ff2 <= r_stop_ff1;
        end
    end

    assign w_clkin_stop = r_stop_ff2;
`else
    // Clock loss is seen only through the counter dropping I_freq_set
    logic w_unused_clkin;
    assign w_unused_clkin = I_clkin_stopped;
    assign w_clkin_stop   = 1'b0;
`endif

    freq_drift_cmp u_drift (
        .i_word  (I_freq_word),
        .i_ref   (r_word),
        .i_tol   (TOL),
        .o_drift (w_drift)
    );

    // Next-state logic: abort first, then clock-stop, then per-state rules
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_retry_clr = 1'b0;
        w_retry_inc = 1'b0;
        if (r_state != ST_IDLE && !w_arm) begin
            w_next = ST_IDLE;
        end else if ((r_state == ST_WAIT_LOCK || r_state == ST_LOCKED) && w_clkin_stop) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arm) begin
                        w_next      = ST_RST;
                        w_latch     = 1'b1;
                        w_retry_clr = 1'b1;
                    end
                end
                ST_RST: begin
                    if (r_timer >= RST_LAST) w_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_locked) begin
                        w_next = ST_LOCKED;
                    end else if (r_timer >= TO_LAST) begin
                        if (r_retry >= RETRY_MAX) begin
                            w_next = ST_FAULT;
                        end else begin
                            w_next      = ST_RST;
                            w_retry_inc = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if ((I_freq_mode != r_mode) || w_drift) begin
                        w_next      = ST_RST;
                        w_latch     = 1'b1;
                        w_retry_clr = 1'b1;
                    end else if (!w_locked) begin
                        w_next      = ST_RST;
                        w_retry_clr = 1'b1;
                    end
                end
                ST_FAULT: begin
                    w_next = ST_FAULT;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, timer, retry count, latched measurement and registered outputs
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_retry   <= '0;
            r_word    <= '0;
            r_mode    <= 1'b0;
            r_dcm_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_timer != TIMER_MAX) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_retry_clr) begin
                r_retry <= '0;
            end else if (w_retry_inc && r_retry < RETRY_MAX) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_latch) begin
                r_word <= I_freq_word;
                r_mode <= I_freq_mode;
            end
            r_dcm_rst <= !(w_next == ST_WAIT_LOCK || w_next == ST_LOCKED);
            r_ready   <= (w_next == ST_LOCKED);
            r_fault   <= (w_next == ST_FAULT);
        end
    end

    assign O_dcm_rst   = r_dcm_rst;
    assign O_dcm_mode  = r_mode;
    assign O_ready     = r_ready;
    assign O_fault     = r_fault;
    assign O_retry_cnt = r_retry;
    assign O_dbg_state = r_state;

endmodule
